// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one Booth step per clock behind a start/done handshake.
// Operands are extended to WIDTH+1 bits so signed and unsigned modes share one Booth datapath.
module booth_mult_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int W1 = WIDTH + 1;
   localparam int CW = $clog2(W1 + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state;
   logic [W1-1:0] a_reg;
   logic [W1-1:0] q_reg;
   logic [W1-1:0] m_reg;
   logic          q_m1;
   logic [CW-1:0] cnt;

   logic [W1-1:0] m_ext;
   logic [W1-1:0] q_ext;
   logic [W1-1:0] sum;
   logic [W1-1:0] a_nxt;
   logic [W1-1:0] q_nxt;

   always_comb begin
      m_ext = {signed_mode & multiplicand[WIDTH-1], multiplicand};
      q_ext = {signed_mode & multiplier[WIDTH-1], multiplier};

      sum = a_reg;
      case ({q_reg[0], q_m1})
         2'b10:   sum = a_reg - m_reg;
         2'b01:   sum = a_reg + m_reg;
         default: sum = a_reg;
      endcase

      // arithmetic right shift of {A,Q,q_m1}; q_m1 takes the old Q[0] in the always_ff
      a_nxt = {sum[W1-1], sum[W1-1:1]};
      q_nxt = {sum[0], q_reg[W1-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         a_reg   <= '0;
         q_reg   <= '0;
         m_reg   <= '0;
         q_m1    <= 1'b0;
         cnt     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  m_reg <= m_ext;
                  q_reg <= q_ext;
                  a_reg <= '0;
                  q_m1  <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_reg <= a_nxt;
               q_reg <= q_nxt;
               q_m1  <= q_reg[0];
               cnt   <= cnt + CW'(1);
               if (cnt == CW'(W1 - 1)) begin
                  // low 2*WIDTH bits of the shifted {A,Q}
                  product <= {a_nxt[WIDTH-2:0], q_nxt};
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: WIDTH=8 directed/random/handshake/reset tests and a WIDTH=4 exhaustive sweep.
module tb_booth_mult_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        start8 = 1'b0, sm8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8;
   logic [15:0] product8;

   logic        start4 = 1'b0, sm4 = 1'b0;
   logic [3:0]  a4 = '0, b4 = '0;
   logic        busy4, done4;
   logic [7:0]  product4;

   booth_mult_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
      .multiplicand(a8), .multiplier(b8),
      .busy(busy8), .done(done8), .product(product8)
   );

   booth_mult_seq #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
      .multiplicand(a4), .multiplier(b4),
      .busy(busy4), .done(done4), .product(product4)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   logic rst_q = 1'b0;

   logic [15:0] exp8_q[$];
   int          acc8_q[$];
   logic [7:0]  exp4_q[$];
   int          acc4_q[$];

   always @(posedge clk) begin
      cyc   = cyc + 1;
      rst_q <= rst;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: interpret operands per mode, multiply as integers.
   function automatic longint ref_mul(input int w, input bit s, input longint a, input longint b);
      longint x = a;
      longint y = b;
      if (s && x[w-1]) x = x - (longint'(1) << w);
      if (s && y[w-1]) y = y - (longint'(1) << w);
      return x * y;
   endfunction

   // WIDTH=8 monitor
   logic [15:0] held8 = '0;
   int          bcnt8 = 0;
   always @(negedge clk) begin
      if (rst_q) begin
         check("rst_busy8", busy8, 0);
         check("rst_done8", done8, 0);
         check("rst_product8", product8, 0);
         exp8_q.delete();
         acc8_q.delete();
         held8 = '0;
         bcnt8 = 0;
      end else begin
         if (busy8) bcnt8++;
         if (done8) begin
            if (exp8_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done8: got product %0h with nothing outstanding", product8);
            end else begin
               check("product8", product8, exp8_q.pop_front());
               check("latency8", cyc - acc8_q.pop_front(), 9);
               check("busy_len8", bcnt8, 9);
            end
            held8 = product8;
            bcnt8 = 0;
         end else begin
            check("hold8", product8, held8);
         end
      end
   end

   // WIDTH=4 monitor
   always @(negedge clk) begin
      if (rst_q) begin
         exp4_q.delete();
         acc4_q.delete();
      end else if (done4) begin
         if (exp4_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done4: got product %0h with nothing outstanding", product4);
         end else begin
            check("product4", product4, exp4_q.pop_front());
            check("latency4", cyc - acc4_q.pop_front(), 5);
         end
      end
   end

   // Called at a negedge; the following posedge is the acceptance edge.
   task automatic op8(input bit s, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
      start8 = 1'b1;
      sm8    = s;
      a8     = a;
      b8     = b;
      exp8_q.push_back(exp);
      acc8_q.push_back(cyc + 1);
      @(posedge clk);
      #1;
      start8 = 1'b0;
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      sm8    = 1'($urandom);
   endtask

   task automatic wait8();
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done8) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL wait8_timeout: done8 still 0 after 30 cycles, required 1");
   endtask

   task automatic op4(input bit s, input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
      start4 = 1'b1;
      sm4    = s;
      a4     = a;
      b4     = b;
      exp4_q.push_back(exp);
      acc4_q.push_back(cyc + 1);
      @(posedge clk);
      #1;
      start4 = 1'b0;
      a4     = 4'($urandom);
      b4     = 4'($urandom);
   endtask

   task automatic wait4();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done4) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL wait4_timeout: done4 still 0 after 20 cycles, required 1");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ra, rb;
      bit         rs;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // directed WIDTH=8 cases; consecutive op8 after wait8 are back-to-back
      op8(1'b1, 8'hFD, 8'h05, 16'hFFF1); wait8();
      @(negedge clk);
      op8(1'b0, 8'hFF, 8'hFF, 16'hFE01); wait8();
      op8(1'b1, 8'hFF, 8'hFF, 16'h0001); wait8();
      op8(1'b1, 8'h80, 8'h80, 16'h4000); wait8();
      op8(1'b1, 8'h80, 8'h7F, 16'hC080); wait8();
      op8(1'b1, 8'h00, 8'($urandom), 16'h0000); wait8();
      op8(1'b0, 8'($urandom), 8'h00, 16'h0000); wait8();

      // start pulse mid-run must be ignored
      @(negedge clk);
      op8(1'b1, 8'd7, 8'hF7, 16'hFFC1);
      repeat (3) @(negedge clk);
      start8 = 1'b1; sm8 = 1'b0; a8 = 8'h55; b8 = 8'h33;
      @(negedge clk);
      start8 = 1'b0;
      wait8();

      // reset on step 4 aborts the run
      @(negedge clk);
      op8(1'b0, 8'd200, 8'd100, 16'(ref_mul(8, 1'b0, 200, 100)));
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      op8(1'b1, 8'hC3, 8'h5A, 16'(ref_mul(8, 1'b1, 64'hC3, 64'h5A))); wait8();

      for (int i = 0; i < 200; i++) begin
         rs = 1'($urandom);
         ra = 8'($urandom);
         rb = 8'($urandom);
         op8(rs, ra, rb, 16'(ref_mul(8, rs, longint'(ra), longint'(rb))));
         wait8();
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      // WIDTH=4 directed then exhaustive back-to-back sweep
      @(negedge clk);
      op4(1'b1, 4'h8, 4'h7, 8'hC8); wait4();
      op4(1'b0, 4'hF, 4'hF, 8'hE1); wait4();
      for (int unsigned s = 0; s < 2; s++) begin
         for (int unsigned a = 0; a < 16; a++) begin
            for (int unsigned b = 0; b < 16; b++) begin
               op4(1'(s), 4'(a), 4'(b), 8'(ref_mul(4, 1'(s), longint'(a), longint'(b))));
               wait4();
            end
         end
      end

      repeat (12) @(negedge clk);
      check("drain8", exp8_q.size(), 0);
      check("drain4", exp4_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
